// File: rtl/xls_ram_pkg.sv
// Shared constants and partition-mask helpers for the XLS channel RAMs.
// Helpers work on MAX_DW-wide words; callers zero-extend and truncate.
package xls_ram_pkg;
  localparam int COLLISION_WRITE_FIRST = 0;
  localparam int COLLISION_READ_FIRST  = 1;
  localparam int MAX_DW = 256;
  localparam int MAX_NP = 256;

  function automatic logic [MAX_DW-1:0] expand_mask(input logic [MAX_NP-1:0] mask, input int pw);
    logic [MAX_DW-1:0] m;
    logic [7:0] pi;
    m = '0;
    for (int b = 0; b < MAX_DW; b++) begin
      pi = 8'(b / pw);
      m[b] = mask[pi];
    end
    return m;
  endfunction

  function automatic logic [MAX_DW-1:0] merge_partitions(input logic [MAX_DW-1:0] old_w,
                                                         input logic [MAX_DW-1:0] new_w,
                                                         input logic [MAX_NP-1:0] mask,
                                                         input int pw);
    logic [MAX_DW-1:0] m;
    m = expand_mask(mask, pw);
    return (old_w & ~m) | (new_w & m);
  endfunction
endpackage

// File: rtl/xls_chan_fifo.sv
// Valid/ready FIFO; out_data reads as zero while empty.
module xls_chan_fifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_vld,
  input  logic             out_rdy
);
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);
  localparam logic [PTRW-1:0] LAST = PTRW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             push, pop;

  assign out_vld  = (count_q != '0);
  assign out_data = out_vld ? mem_q[rd_ptr_q] : '0;
  assign pop      = out_vld && out_rdy;
  assign in_rdy   = (count_q != FULL) || pop;
  assign push     = in_vld && in_rdy;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    count_d = count_q + CNTW'(push) - CNTW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end
endmodule

// File: rtl/sdpram_xls_chan_pipe.sv
// Semi-dual-port RAM behind XLS valid/ready channels: masked writes with
// multiple pending completions, pipelined masked reads into a response FIFO.
module sdpram_xls_chan_pipe
  import xls_ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int NUM_PARTITIONS = 4,
  parameter int READ_LATENCY   = 2,
  parameter int COLLISION_MODE = 0,
  parameter int WR_RESP_MAX    = 4
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [ADDR_WIDTH+DATA_WIDTH+NUM_PARTITIONS-1:0] wr_req_data,
  input  logic                                           wr_req_vld,
  output logic                                           wr_req_rdy,
  output logic                                           wr_resp_vld,
  input  logic                                           wr_resp_rdy,
  input  logic [ADDR_WIDTH+NUM_PARTITIONS-1:0]            rd_req_data,
  input  logic                                           rd_req_vld,
  output logic                                           rd_req_rdy,
  output logic [DATA_WIDTH-1:0]                          rd_resp_data,
  output logic                                           rd_resp_vld,
  input  logic                                           rd_resp_rdy
);
  localparam int PW            = DATA_WIDTH / NUM_PARTITIONS;
  localparam int DEPTH         = 2 ** ADDR_WIDTH;
  localparam int RD_FIFO_DEPTH = READ_LATENCY + 1;
  localparam int WCW           = $clog2(WR_RESP_MAX + 1);
  localparam int RCW           = $clog2(RD_FIFO_DEPTH + 1);
  localparam logic [WCW-1:0] WR_MAX = WCW'(WR_RESP_MAX);
  localparam logic [RCW-1:0] RD_MAX = RCW'(RD_FIFO_DEPTH);

  if (DATA_WIDTH % NUM_PARTITIONS != 0) begin : g_bad_dw
    $error("DATA_WIDTH must be divisible by NUM_PARTITIONS");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
    $error("READ_LATENCY must be in 1..4");
  end
  if (WR_RESP_MAX < 1 || WR_RESP_MAX > 15) begin : g_bad_wmax
    $error("WR_RESP_MAX must be in 1..15");
  end

  logic [ADDR_WIDTH-1:0]     wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0]     wr_data, wr_word, rd_raw, rd_word, push_data;
  logic [NUM_PARTITIONS-1:0] wr_mask, rd_mask;
  logic [DATA_WIDTH-1:0]     mem [DEPTH];
  logic [WCW-1:0]            wr_pend_q, wr_pend_d;
  logic [RCW-1:0]            rd_occ_q, rd_occ_d;
  logic                      live_q;
  logic                      wr_ack, wr_resp_ack, rd_ack, rd_resp_ack, push_vld, fifo_in_rdy;

  assign {wr_addr, wr_data, wr_mask} = wr_req_data;
  assign {rd_addr, rd_mask}          = rd_req_data;

  // live_q holds both request readies low through reset and its release edge.
  assign wr_resp_vld = (wr_pend_q != '0);
  assign wr_resp_ack = wr_resp_vld && wr_resp_rdy;
  assign wr_req_rdy  = live_q && ((wr_pend_q < WR_MAX) || wr_resp_ack);
  assign wr_ack      = wr_req_vld && wr_req_rdy;
  assign rd_resp_ack = rd_resp_vld && rd_resp_rdy;
  assign rd_req_rdy  = live_q && ((rd_occ_q - RCW'(rd_resp_ack)) < RD_MAX);
  assign rd_ack      = rd_req_vld && rd_req_rdy;

  always_comb begin
    wr_pend_d = wr_pend_q + WCW'(wr_ack) - WCW'(wr_resp_ack);
    rd_occ_d  = rd_occ_q + RCW'(rd_ack) - RCW'(rd_resp_ack);
    wr_word   = DATA_WIDTH'(merge_partitions(MAX_DW'(mem[wr_addr]), MAX_DW'(wr_data),
                                             MAX_NP'(wr_mask), PW));
    rd_raw    = mem[rd_addr];
    // Write-first bypass: the merged word already keeps unwritten partitions old.
    if (COLLISION_MODE == COLLISION_WRITE_FIRST && wr_ack && wr_addr == rd_addr)
      rd_raw = wr_word;
    rd_word   = rd_raw & DATA_WIDTH'(expand_mask(MAX_NP'(rd_mask), PW));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_pend_q <= '0;
      rd_occ_q  <= '0;
      live_q    <= 1'b0;
    end else begin
      wr_pend_q <= wr_pend_d;
      rd_occ_q  <= rd_occ_d;
      live_q    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ack) mem[wr_addr] <= wr_word;
  end

  if (READ_LATENCY == 1) begin : g_nopipe
    assign push_vld  = rd_ack;
    assign push_data = rd_word;
  end else begin : g_pipe
    localparam int STAGES = READ_LATENCY - 1;
    logic [STAGES-1:0]                 vld_pipe_q, vld_pipe_d;
    logic [STAGES-1:0][DATA_WIDTH-1:0] dat_pipe_q, dat_pipe_d;

    always_comb begin
      vld_pipe_d    = vld_pipe_q;
      dat_pipe_d    = dat_pipe_q;
      vld_pipe_d[0] = rd_ack;
      dat_pipe_d[0] = rd_word;
      for (int s = 1; s < STAGES; s++) begin
        vld_pipe_d[s] = vld_pipe_q[s-1];
        dat_pipe_d[s] = dat_pipe_q[s-1];
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) vld_pipe_q <= '0;
      else      vld_pipe_q <= vld_pipe_d;
    end

    always_ff @(posedge clk) dat_pipe_q <= dat_pipe_d;

    assign push_vld  = vld_pipe_q[STAGES-1];
    assign push_data = dat_pipe_q[STAGES-1];
  end

  xls_chan_fifo #(.DEPTH(RD_FIFO_DEPTH), .WIDTH(DATA_WIDTH)) u_rd_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_data  (push_data),
    .in_vld   (push_vld),
    .in_rdy   (fifo_in_rdy),
    .out_data (rd_resp_data),
    .out_vld  (rd_resp_vld),
    .out_rdy  (rd_resp_rdy)
  );

  // Admission is bounded by rd_occ, so the FIFO can never refuse a pipeline exit.
  always_ff @(posedge clk) begin
    if (push_vld) assert (fifo_in_rdy);
  end
endmodule

// File: tb/tb_sdpram_xls_chan_pipe.sv
// Scoreboard bench: a write-first and a read-first instance share all inputs.
module tb_sdpram_xls_chan_pipe;
  localparam int AW = 10, DW = 32, NP = 4;

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic [AW+DW+NP-1:0] wr_req_data;
  logic [AW+NP-1:0]    rd_req_data;
  logic wr_req_vld, wr_resp_rdy, rd_req_vld, rd_resp_rdy;
  logic wr_req_rdy_a, wr_resp_vld_a, rd_req_rdy_a, rd_resp_vld_a;
  logic wr_req_rdy_b, wr_resp_vld_b, rd_req_rdy_b, rd_resp_vld_b;
  logic [DW-1:0] rd_resp_data_a, rd_resp_data_b;

  sdpram_xls_chan_pipe #(.COLLISION_MODE(0)) u_wf (
    .clk(clk), .rst(rst),
    .wr_req_data(wr_req_data), .wr_req_vld(wr_req_vld), .wr_req_rdy(wr_req_rdy_a),
    .wr_resp_vld(wr_resp_vld_a), .wr_resp_rdy(wr_resp_rdy),
    .rd_req_data(rd_req_data), .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy_a),
    .rd_resp_data(rd_resp_data_a), .rd_resp_vld(rd_resp_vld_a), .rd_resp_rdy(rd_resp_rdy));

  sdpram_xls_chan_pipe #(.COLLISION_MODE(1)) u_rf (
    .clk(clk), .rst(rst),
    .wr_req_data(wr_req_data), .wr_req_vld(wr_req_vld), .wr_req_rdy(wr_req_rdy_b),
    .wr_resp_vld(wr_resp_vld_b), .wr_resp_rdy(wr_resp_rdy),
    .rd_req_data(rd_req_data), .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy_b),
    .rd_resp_data(rd_resp_data_b), .rd_resp_vld(rd_resp_vld_b), .rd_resp_rdy(rd_resp_rdy));

  int chk = 0, err = 0, cyc = 0, first_acc = -1;
  logic [31:0] q_a[$], q_b[$];
  int pop_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever a response handshake is about to occur.
  always @(negedge clk) begin
    if (rst) begin
      if (rd_resp_vld_a && rd_resp_rdy) begin
        pop_cyc.push_back(cyc);
        if (q_a.size() == 0) begin
          chk++; err++;
          $display("FAIL rd_a_unexpected: got %h expected no response", rd_resp_data_a);
        end else check("rd_a_data", rd_resp_data_a, q_a.pop_front());
      end
      if (rd_resp_vld_b && rd_resp_rdy) begin
        if (q_b.size() == 0) begin
          chk++; err++;
          $display("FAIL rd_b_unexpected: got %h expected no response", rd_resp_data_b);
        end else check("rd_b_data", rd_resp_data_b, q_b.pop_front());
      end
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NP-1:0] m);
    int n = 0;
    bit acc = 0;
    wr_req_vld = 1; wr_req_data = {a, d, m};
    while (!acc && n < 50) begin
      @(negedge clk); acc = wr_req_rdy_a;
      @(posedge clk); #1; n++;
    end
    wr_req_vld = 0;
    if (!acc) begin chk++; err++; $display("FAIL wr_timeout: got no accept expected accept"); end
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [NP-1:0] m,
                    input logic [DW-1:0] ea, input logic [DW-1:0] eb);
    int n = 0;
    bit acc = 0;
    rd_req_vld = 1; rd_req_data = {a, m};
    while (!acc && n < 50) begin
      @(negedge clk); acc = rd_req_rdy_a;
      if (acc && first_acc < 0) first_acc = cyc;
      @(posedge clk); #1; n++;
    end
    rd_req_vld = 0;
    if (!acc) begin chk++; err++; $display("FAIL rd_timeout: got no accept expected accept"); end
    else begin q_a.push_back(ea); q_b.push_back(eb); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, n;
    wr_req_vld = 0; rd_req_vld = 0; wr_req_data = '0; rd_req_data = '0;
    wr_resp_rdy = 1; rd_resp_rdy = 1;
    #12;
    check("in_reset_flags", {28'd0, wr_req_rdy_a, rd_req_rdy_a, wr_resp_vld_a, rd_resp_vld_a}, 0);
    check("in_reset_data", rd_resp_data_a, 0);
    @(negedge clk); rst = 1;
    @(posedge clk); @(negedge clk);
    check("idle_flags", {28'd0, wr_req_rdy_a, rd_req_rdy_a, wr_resp_vld_a, rd_resp_vld_a}, 32'hC);
    check("idle_data", rd_resp_data_a, 0);
    @(posedge clk); #1;

    // Masked write then masked reads.
    wr(10'h005, 32'hAABBCCDD, 4'hF);
    wr(10'h005, 32'h11223344, 4'h5);
    rd(10'h005, 4'hF, 32'hAA22CC44, 32'hAA22CC44);
    rd(10'h005, 4'h3, 32'h0000CC44, 32'h0000CC44);
    for (int i = 0; i < 8; i++) wr(AW'(16 + i), 32'hC0DE0000 + i, 4'hF);
    wr(10'h007, 32'h0, 4'hF);
    repeat (4) @(posedge clk); #1;

    // Latency and throughput.
    pop_cyc.delete(); first_acc = -1;
    for (int i = 0; i < 8; i++) rd(AW'(16 + i), 4'hF, 32'hC0DE0000 + i, 32'hC0DE0000 + i);
    repeat (6) @(posedge clk); #1;
    check("lat_count", pop_cyc.size(), 8);
    if (pop_cyc.size() == 8) begin
      check("lat_first", pop_cyc[0] - first_acc, 2);
      check("lat_burst", pop_cyc[7] - pop_cyc[0], 7);
    end

    // Backpressure on read responses.
    rd_resp_rdy = 0; acc = 0;
    for (int c = 0; c < 6; c++) begin
      rd_req_vld = 1; rd_req_data = {AW'(16 + acc), 4'hF};
      @(negedge clk);
      if (rd_req_rdy_a) begin
        q_a.push_back(32'hC0DE0000 + acc); q_b.push_back(32'hC0DE0000 + acc); acc++;
      end
      @(posedge clk); #1;
    end
    rd_req_vld = 0;
    check("bp_accepted", acc, 3);
    check("bp_rdy_low", rd_req_rdy_a, 0);
    rd_resp_rdy = 1;
    @(negedge clk);
    check("bp_rdy_on_pop", rd_req_rdy_a, 1);
    repeat (5) @(posedge clk); #1;

    // Same-cycle write and read on address 7.
    wr_req_vld = 1; wr_req_data = {10'h007, 32'hFFFFFFFF, 4'h3};
    rd_req_vld = 1; rd_req_data = {10'h007, 4'hF};
    @(negedge clk);
    check("coll_both_rdy", {30'd0, wr_req_rdy_a, rd_req_rdy_a}, 3);
    q_a.push_back(32'h0000FFFF); q_b.push_back(32'h00000000);
    @(posedge clk); #1;
    wr_req_vld = 0; rd_req_vld = 0;
    rd(10'h007, 4'hF, 32'h0000FFFF, 32'h0000FFFF);
    wr(10'h007, 32'h12345678, 4'hF);
    rd(10'h007, 4'hF, 32'h12345678, 32'h12345678);
    repeat (4) @(posedge clk); #1;

    // Write completions with backpressure, then reset mid-stream.
    wr_resp_rdy = 0; acc = 0;
    for (int c = 0; c < 6; c++) begin
      wr_req_vld = 1; wr_req_data = {AW'(32 + acc), 32'h5A5A0000, 4'hF};
      @(negedge clk);
      if (wr_req_rdy_a) acc++;
      @(posedge clk); #1;
    end
    check("wc_accepted", acc, 4);
    check("wc_rdy_low", wr_req_rdy_a, 0);
    check("wc_resp_vld", wr_resp_vld_a, 1);
    #2; rst = 0; wr_req_vld = 0;
    #1;
    check("rst_flags", {28'd0, wr_req_rdy_a, rd_req_rdy_a, wr_resp_vld_a, rd_resp_vld_a}, 0);
    check("rst_data", rd_resp_data_a, 0);
    @(negedge clk); rst = 1; wr_resp_rdy = 1;
    n = 0;
    repeat (6) begin @(negedge clk); if (wr_resp_vld_a) n++; end
    check("no_stale_cmpl", n, 0);
    @(posedge clk); #1;
    rd(10'h005, 4'hF, 32'hAA22CC44, 32'hAA22CC44);
    repeat (5) @(posedge clk); #1;

    check("sb_empty_a", q_a.size(), 0);
    check("sb_empty_b", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end
endmodule
